// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: pops words from the FIFO read port into a 2-entry holding
// buffer and presents them as a valid/ready stream. out_last frames packets of
// PKT_LEN words, and words_read counts every delivered word.
module fifo_read_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  empty,
    output logic                  read_en,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [CNT_WIDTH-1:0]  words_read
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    // Occupancy of the holding buffer
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_t;

    occ_t                  r_state;
    occ_t                  w_state_next;
    logic                  r_inflight;    // a pop was issued last cycle; read_data is valid now
    logic [DATA_WIDTH-1:0] r_buf0;        // head of the buffer
    logic [DATA_WIDTH-1:0] r_buf1;        // second entry
    logic [BEAT_W-1:0]     r_beat;
    logic [CNT_WIDTH-1:0]  r_words;

    logic                  w_pop;
    logic                  w_capture;
    logic [2:0]            w_pending;

    assign w_capture = r_inflight;
    assign w_pop     = out_valid & out_ready;

    // Entries held after this cycle plus the word already on its way; a new pop
    // is only allowed if that total stays below the buffer depth.
    assign w_pending = {1'b0, r_state} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign read_en   = reset_n & enable & ~empty & (w_pending < 3'd2);

    assign words_read = r_words;

    // Occupancy state register
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Occupancy next state: captures fill, pops drain, both together cancel
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_EMPTY: if (w_capture)            w_state_next = S_ONE;
            S_ONE: begin
                if (w_capture && !w_pop)       w_state_next = S_FULL;
                else if (!w_capture && w_pop)  w_state_next = S_EMPTY;
            end
            S_FULL:  if (w_pop && !w_capture)  w_state_next = S_ONE;
            default:                           w_state_next = S_EMPTY;
        endcase
    end

    // Stream outputs derived from occupancy and the buffer head
    always_comb begin
        out_valid = (r_state != S_EMPTY);
        out_data  = r_buf0;
        out_last  = (r_state != S_EMPTY) && (r_beat == LAST_BEAT);
    end

    // In-flight flag follows the accepted pop by one cycle
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= read_en;
        end
    end

    // Buffer entries: head advances on pop, arriving word lands in the first free slot
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            if (w_capture && ((r_state == S_EMPTY) || ((r_state == S_ONE) && w_pop))) begin
                r_buf0 <= read_data;
            end else if (w_pop && (r_state == S_FULL)) begin
                r_buf0 <= r_buf1;
            end
            if (w_capture && (((r_state == S_ONE) && !w_pop) || ((r_state == S_FULL) && w_pop))) begin
                r_buf1 <= read_data;
            end
        end
    end

    // Packet beat position and delivered-word counter advance on every transfer
    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat  <= '0;
            r_words <= '0;
        end else if (w_pop) begin
            r_beat  <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
            r_words <= r_words + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer: drives a queue-backed FIFO into two streamer instances
// (default counter width and a 4-bit counter) and checks every cycle against a
// queue model of the holding buffer, plus directed literal scenarios.
module tb_fifo_read_streamer;

    localparam int PL = 4;

    logic       clk = 1'b0;
    logic       reset_n, enable, empty, out_ready;
    logic [7:0] read_data;
    logic       read_en, out_valid, out_last;
    logic [7:0] out_data;
    logic [15:0] words_read;
    logic       read_en4, out_valid4, out_last4;
    logic [7:0] out_data4;
    logic [3:0] words_read4;

    always #5 clk = ~clk;

    fifo_read_streamer #(.DATA_WIDTH(8), .PKT_LEN(PL), .CNT_WIDTH(16)) dut (
        .rd_clk(clk), .reset_n(reset_n), .enable(enable), .empty(empty),
        .read_en(read_en), .read_data(read_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .words_read(words_read)
    );

    fifo_read_streamer #(.DATA_WIDTH(8), .PKT_LEN(PL), .CNT_WIDTH(4)) dut4 (
        .rd_clk(clk), .reset_n(reset_n), .enable(enable), .empty(empty),
        .read_en(read_en4), .read_data(read_data), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_last(out_last4),
        .words_read(words_read4)
    );

    int checks = 0;
    int errors = 0;

    // Environment FIFO and model state
    logic [7:0]  fifo_q[$];
    logic [7:0]  m_buf[$];
    bit          m_infl;
    logic [7:0]  m_infl_word;
    int unsigned m_deliv;
    logic [7:0]  next_rd;

    // Values sampled in the most recent cycle, for directed checks
    bit          s_read_en, s_valid, s_last;
    logic [7:0]  s_data;
    logic [15:0] s_words;
    logic [3:0]  s_words4;
    logic [7:0]  xfer_q[$];
    bit          xlast_q[$];

    bit          ren_log[6];
    bit          val_log[6];
    logic [7:0]  dat_log[6];
    int          cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, compare against the model, advance the model
    task automatic cycle(input bit en, input bit rdy, input bit stall, input bit rstn);
        bit         e_valid, e_last, e_ren, e_pop;
        logic [7:0] e_data, w;
        int         pend;
        @(negedge clk);
        read_data = next_rd;
        enable    = en;
        out_ready = rdy;
        reset_n   = rstn;
        empty     = (fifo_q.size() == 0) || stall;
        #1;
        if (!rstn) begin
            m_buf.delete();
            m_infl  = 1'b0;
            m_deliv = 0;
        end
        e_valid = (m_buf.size() > 0);
        e_data  = e_valid ? m_buf[0] : 8'h00;
        e_last  = e_valid && ((m_deliv % PL) == PL - 1);
        e_pop   = e_valid && rdy;
        pend    = m_buf.size() + int'(m_infl) - int'(e_pop);
        e_ren   = rstn && en && !empty && (pend < 2);

        chk("read_en", read_en, e_ren);
        chk("out_valid", out_valid, e_valid);
        if (e_valid || !rstn) chk("out_data", out_data, e_data);
        chk("out_last", out_last, e_last);
        chk("words_read", words_read, m_deliv[15:0]);
        chk("w4_read_en", read_en4, e_ren);
        chk("w4_out_valid", out_valid4, e_valid);
        chk("w4_words_read", words_read4, m_deliv[3:0]);

        s_read_en = read_en;
        s_valid   = out_valid;
        s_last    = out_last;
        s_data    = out_data;
        s_words   = words_read;
        s_words4  = words_read4;
        if (out_valid && rdy && rstn) begin
            xfer_q.push_back(out_data);
            xlast_q.push_back(out_last);
            $display("xfer data=%h last=%0d words_before=%0d", out_data, out_last, words_read);
        end

        if (rstn) begin
            if (e_pop) begin
                void'(m_buf.pop_front());
                m_deliv++;
            end
            if (m_infl) m_buf.push_back(m_infl_word);
        end
        w = 8'($urandom);
        if (read_en && fifo_q.size() > 0) w = fifo_q.pop_front();
        next_rd     = w;
        m_infl      = e_ren;
        m_infl_word = w;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; empty = 1'b1; out_ready = 1'b0;
        read_data = 8'h00; next_rd = 8'h00; m_infl = 1'b0; m_infl_word = 8'h00; m_deliv = 0;

        // Reset with a non-empty FIFO: no pops, nothing valid
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'(i + 1));
        repeat (3) cycle(1, 1, 0, 0);
        chk("t1_read_en", s_read_en, 0);
        chk("t1_out_valid", s_valid, 0);
        chk("t1_words_read", s_words, 0);
        fifo_q.delete();
        cycle(1, 1, 0, 0);
        repeat (2) cycle(1, 1, 0, 1);

        // Two-cycle latency, one word per cycle
        fifo_q.push_back(8'hA1); fifo_q.push_back(8'hB2); fifo_q.push_back(8'hC3);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 0, 1);
            ren_log[i] = s_read_en; val_log[i] = s_valid; dat_log[i] = s_data;
        end
        for (int i = 0; i < 6; i++) begin
            chk("t2_read_en", ren_log[i], (i < 3) ? 1 : 0);
            chk("t2_out_valid", val_log[i], (i >= 2 && i <= 4) ? 1 : 0);
        end
        chk("t2_data_c2", dat_log[2], 8'hA1);
        chk("t2_data_c3", dat_log[3], 8'hB2);
        chk("t2_data_c4", dat_log[4], 8'hC3);
        chk("t2_words_read", s_words, 3);

        // Backpressure: exactly two pops, head held, then in-order drain
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h10 + i));
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 0, 1);
            if (s_read_en) cnt++;
        end
        chk("t3_pop_count", cnt, 2);
        chk("t3_head_data", s_data, 8'h10);
        xfer_q.delete(); xlast_q.delete();
        for (int i = 0; i < 40 && xfer_q.size() < 8; i++) cycle(1, 1, 0, 1);
        chk("t3_xfer_count", xfer_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < xfer_q.size()) chk("t3_order", xfer_q[i], 8'(8'h10 + i));

        // Framing and counter wrap after a fresh reset
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 17; i++) fifo_q.push_back(8'(8'h40 + i));
        xfer_q.delete(); xlast_q.delete();
        for (int i = 0; i < 60 && xfer_q.size() < 17; i++) cycle(1, 1, 0, 1);
        chk("t4_xfer_count", xfer_q.size(), 17);
        for (int i = 0; i < 17; i++)
            if (i < xlast_q.size()) chk("t4_last", xlast_q[i], (i % 4 == 3) ? 1 : 0);
        cycle(1, 1, 0, 1);
        chk("t4_words_read", s_words, 17);
        chk("t4_words_read_w4", s_words4, 1);

        // Enable drop right after the first pop
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h50 + i));
        xfer_q.delete(); xlast_q.delete();
        cycle(1, 1, 0, 1);
        chk("t5_first_read_en", s_read_en, 1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 0, 1);
            if (s_read_en) cnt++;
        end
        chk("t5_read_en_while_off", cnt, 0);
        chk("t5_delivered", xfer_q.size(), 1);
        if (xfer_q.size() > 0) chk("t5_word", xfer_q[0], 8'h50);
        for (int i = 0; i < 40 && xfer_q.size() < 6; i++) cycle(1, 1, 0, 1);
        chk("t5_drain", xfer_q.size(), 6);

        // Reset mid-stream discards buffered and in-flight words
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'(8'h60 + i));
        repeat (4) cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 0);
        chk("t6_valid_in_reset", s_valid, 0);
        chk("t6_read_en_in_reset", s_read_en, 0);
        cycle(1, 1, 0, 0);
        xfer_q.delete(); xlast_q.delete();
        for (int i = 0; i < 20 && xfer_q.size() < 1; i++) cycle(1, 1, 0, 1);
        chk("t6_xfer_seen", xfer_q.size(), 1);
        if (xfer_q.size() > 0) chk("t6_next_word", xfer_q[0], 8'h64);
        for (int i = 0; i < 60 && (fifo_q.size() > 0 || m_buf.size() > 0 || m_infl); i++)
            cycle(1, 1, 0, 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) fifo_q.push_back(8'($urandom));
            cycle($urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 199) != 0);
        end
        for (int i = 0; i < 60; i++) cycle(1, 1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
